bus_fabric: RTL and testbench
=============================

# bus_fabric

Parametrised CPU-side memory fabric for the K86 board tops. It replaces hand-written address decode and read muxing with an N-region registered decoder: per-region base/mask matching, per-region wait states, write protection, and a ready handshake toward the CPU. It sits between `cpu` and the on-chip RAM, char and BIOS memories, each assumed to have a 1-cycle synchronous read. It also reports unmapped accesses and writes to read-only regions.

## Interface
Parameters:
- `NREG`, 3: number of regions (1..8).
- `AW`, 20: address width.
- `DW`, 8: data width.
- `BASE`, {20'hFF000, 20'hB8000, 20'h00000}: packed NREG×AW region bases; region i occupies bits [i*AW +: AW].
- `MASK`, {20'hFF000, 20'hFF000, 20'hE0000}: packed NREG×AW match masks.
- `WAIT`, {4'd0, 4'd1, 4'd0}: packed NREG×4 wait-state counts.
- `RO`, 3'b100: per-region read-only flag.
- `DEFAULT_DATA`, 8'hFF: read data for unmapped accesses.

Ports:
- `clock`  in  1  system clock.
- `reset`  in  1  synchronous reset, active high.
- `req`  in  1  CPU access request, held until `ready`.
- `we`  in  1  CPU write strobe, qualified by `req`.
- `address`  in  AW  CPU address.
- `out`  in  DW  CPU write data.
- `in`  out  DW  registered read data to CPU.
- `ready`  out  1  one-cycle access-complete pulse.
- `mem_a`  out  AW  latched address to all regions.
- `mem_d`  out  DW  latched write data.
- `sel`  out  NREG  one-hot region access strobe.
- `wr`  out  NREG  one-hot region write strobe.
- `q`  in  NREG×DW  packed region read data; region i at [i*DW +: DW].
- `fault_clr`  in  1  clears `fault`.
- `fault`  out  1  sticky fault flag.
- `fault_addr`  out  AW  address of the first fault since the last clear.

## Operation
- Match rule: region i matches when (address & MASK_i) == BASE_i. If several regions match, the lowest index wins. If none matches, the access is unmapped.
- FSM states:
  - IDLE → ACCESS: on `req` with a mapped region and WAIT=0. Latches idx, `mem_a`, `mem_d` and we.
  - IDLE → WAIT: on `req` with a mapped region and WAIT>0. Latches the same fields and loads the counter with WAIT_idx.
  - IDLE → CAPTURE: on `req` with an unmapped address.
  - WAIT: decrements the counter each cycle and moves to ACCESS when the counter reaches 1.
  - ACCESS: `sel[idx]`=1 for exactly one cycle. `wr[idx]`=we & !RO_idx. Next state is CAPTURE.
  - CAPTURE: `in` <= q[idx], or DEFAULT_DATA if unmapped. `ready` <= 1. Next state is IDLE.
- In IDLE, `req` is ignored during the cycle `ready` is high. This prevents the still-held request from being re-accepted.
- On a write, `in` still captures q (a don't-care for the CPU).
- Fault is raised in CAPTURE for two cases: an unmapped access (read or write), or a write to an RO region.
  - In that case `fault` <= 1, and `fault_addr` <= `mem_a` only if `fault` was 0.
  - A write to an RO region never asserts `wr`; `sel` still pulses.
- `fault_clr` clears `fault`. If a new fault is raised in the same cycle, the new fault wins and `fault_addr` updates.
- `in` holds its value until the next CAPTURE.

## Timing
- `req` is sampled at edge T.
- Mapped access:
  - WAIT cycles run from T+1 to T+w.
  - `sel` is high during cycle T+1+w.
  - CAPTURE occurs in cycle T+2+w.
  - `ready` and valid `in` appear in cycle T+3+w, so latency is 3+w.
- Unmapped access: CAPTURE occurs in cycle T+1; `ready` appears in cycle T+2.
- Back-to-back throughput: one access per 4+w cycles.
- Reset values and behaviour:
  - The state is IDLE.
  - `sel`, `wr`, `ready` and `fault` are 0; `in` is DEFAULT_DATA.
  - `mem_a`, `mem_d` and `fault_addr` are 0.
  - Reset in any state aborts the access with no `ready` and no further `wr`.
- `mem_a` and `mem_d` are stable from T+1 until the next accepted request.

## Test plan
- Read at 00010 (region 0, q0=8'h5A): `sel`=001 at T+1, `ready`=1 with `in`=5A at T+3, `wr`=000 throughout.
- Write of 8'h41 to B8002 (region 1, WAIT=1): `sel`=010 and `wr`=010 at T+2, `mem_a`=B8002, `mem_d`=41, `ready` at T+4.
- Write to FF123 (region 2, RO):
  - `wr`=000, `ready` at T+3.
  - `fault`=1, `fault_addr`=FF123.
  - A second fault at 30000 leaves `fault_addr` at FF123.
- Read at 30000 (unmapped): no `sel`, `in`=FF, `ready` at T+2, `fault` set. Asserting `fault_clr` with no new fault clears `fault` the next cycle.
- Overlap check with BASE1 temporarily set to 00000 and MASK1=FF000: a read at 00100 selects region 0 only.
- Assert `reset` during the WAIT state of a region 1 access: next cycle is IDLE with `sel`=0, `wr`=0, `ready`=0, `in`=FF, and no `ready` pulse follows.

Source files
------------

// File: rtl/bus_fabric.sv
// CPU-side memory fabric: N-region registered address decoder with wait states,
// write protection, a ready handshake and a sticky fault report.
module bus_fabric #(
    parameter int unsigned         NREG         = 3,
    parameter int unsigned         AW           = 20,
    parameter int unsigned         DW           = 8,
    parameter logic [NREG*AW-1:0]  BASE         = {20'hFF000, 20'hB8000, 20'h00000},
    parameter logic [NREG*AW-1:0]  MASK         = {20'hFF000, 20'hFF000, 20'hE0000},
    parameter logic [NREG*4-1:0]   WAIT         = {4'd0, 4'd1, 4'd0},
    parameter logic [NREG-1:0]     RO           = 3'b100,
    parameter logic [DW-1:0]       DEFAULT_DATA = 8'hFF
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 req,
    input  logic                 we,
    input  logic [AW-1:0]        address,
    input  logic [DW-1:0]        out,
    output logic [DW-1:0]        in,
    output logic                 ready,
    output logic [AW-1:0]        mem_a,
    output logic [DW-1:0]        mem_d,
    output logic [NREG-1:0]      sel,
    output logic [NREG-1:0]      wr,
    input  logic [NREG*DW-1:0]   q,
    input  logic                 fault_clr,
    output logic                 fault,
    output logic [AW-1:0]        fault_addr
);

    localparam int unsigned IW = (NREG > 1) ? $clog2(NREG) : 1;
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS,
        ST_CAPTURE
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [IW-1:0]   idx_q;
    logic            we_q;
    logic            unmapped_q;
    logic [CW-1:0]   cnt_q;

    logic            hit_c;
    logic [IW-1:0]   hit_idx_c;
    logic [CW-1:0]   hit_wait_c;
    logic            accept_c;
    logic [IW-1:0]   acc_idx_c;
    logic            acc_we_c;
    logic [NREG-1:0] acc_onehot_c;
    logic [DW-1:0]   q_sel_c;
    logic            ro_sel_c;
    logic            fault_hit_c;

    logic [NREG-1:0] sel_d;
    logic [NREG-1:0] wr_d;
    logic            ready_d;
    logic [DW-1:0]   in_d;
    logic            fault_d;
    logic [AW-1:0]   fault_addr_d;

    // Address decode; scanning downward lets the lowest matching region win.
    always_comb begin
        hit_c      = 1'b0;
        hit_idx_c  = '0;
        hit_wait_c = '0;
        for (int i = int'(NREG) - 1; i >= 0; i--) begin
            if ((address & MASK[i*AW +: AW]) == BASE[i*AW +: AW]) begin
                hit_c      = 1'b1;
                hit_idx_c  = IW'(i);
                hit_wait_c = WAIT[i*CW +: CW];
            end
        end
    end

    // The cycle after ready the CPU may still hold req; never re-accept it.
    assign accept_c = (state == ST_IDLE) && req && !ready;

    // ACCESS is entered either straight from IDLE (live decode) or from WAIT (latched).
    always_comb begin
        acc_idx_c = (state == ST_IDLE) ? hit_idx_c : idx_q;
        acc_we_c  = (state == ST_IDLE) ? we : we_q;
    end

    always_comb begin
        q_sel_c      = '0;
        ro_sel_c     = 1'b0;
        acc_onehot_c = '0;
        for (int i = 0; i < int'(NREG); i++) begin
            if (idx_q == IW'(i)) begin
                q_sel_c  = q[i*DW +: DW];
                ro_sel_c = RO[i];
            end
            if (acc_idx_c == IW'(i)) begin
                acc_onehot_c[i] = 1'b1;
            end
        end
    end

    assign fault_hit_c = unmapped_q || (we_q && ro_sel_c);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept_c) begin
                    if (!hit_c) begin
                        state_next = ST_CAPTURE;
                    end else if (hit_wait_c == '0) begin
                        state_next = ST_ACCESS;
                    end else begin
                        state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == CW'(1)) begin
                    state_next = ST_ACCESS;
                end
            end
            ST_ACCESS:  state_next = ST_CAPTURE;
            ST_CAPTURE: state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs; a fault raised in CAPTURE beats fault_clr.
    always_comb begin
        sel_d        = '0;
        wr_d         = '0;
        ready_d      = 1'b0;
        in_d         = in;
        fault_d      = fault;
        fault_addr_d = fault_addr;
        if (state_next == ST_ACCESS) begin
            sel_d = acc_onehot_c;
            wr_d  = acc_onehot_c & ~RO & {NREG{acc_we_c}};
        end
        if (fault_clr) begin
            fault_d = 1'b0;
        end
        if (state == ST_CAPTURE) begin
            ready_d = 1'b1;
            in_d    = unmapped_q ? DEFAULT_DATA : q_sel_c;
            if (fault_hit_c) begin
                fault_d = 1'b1;
                if (!fault || fault_clr) begin
                    fault_addr_d = mem_a;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sel        <= '0;
            wr         <= '0;
            ready      <= 1'b0;
            in         <= DEFAULT_DATA;
            fault      <= 1'b0;
            fault_addr <= '0;
            mem_a      <= '0;
            mem_d      <= '0;
            idx_q      <= '0;
            we_q       <= 1'b0;
            unmapped_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            sel        <= sel_d;
            wr         <= wr_d;
            ready      <= ready_d;
            in         <= in_d;
            fault      <= fault_d;
            fault_addr <= fault_addr_d;
            if (accept_c) begin
                mem_a      <= address;
                mem_d      <= out;
                idx_q      <= hit_idx_c;
                we_q       <= we;
                unmapped_q <= !hit_c;
                cnt_q      <= hit_wait_c;
            end else if (state == ST_WAIT) begin
                cnt_q <= cnt_q - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_bus_fabric.sv
// Randomized self-checking bench for bus_fabric against a transaction-level model
// built from the region table, latency rules and fault rules.
module tb_bus_fabric;

    logic        clock = 1'b0;
    logic        reset;
    logic        req;
    logic        req_ovl;
    logic        we;
    logic [19:0] address;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        ready;
    logic [19:0] mem_a;
    logic [7:0]  mem_d;
    logic [2:0]  sel;
    logic [2:0]  wr;
    logic [23:0] q;
    logic        fault_clr;
    logic        fault;
    logic [19:0] fault_addr;

    logic [7:0]  rdata_o;
    logic        ready_o;
    logic [19:0] mem_a_o;
    logic [7:0]  mem_d_o;
    logic [2:0]  sel_o;
    logic [2:0]  wr_o;
    logic        fault_o;
    logic [19:0] fault_addr_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference region table and fault state.
    logic [19:0] m_base [3] = '{20'h00000, 20'hB8000, 20'hFF000};
    logic [19:0] m_mask [3] = '{20'hE0000, 20'hFF000, 20'hFF000};
    int          m_wait [3] = '{0, 1, 0};
    bit          m_ro   [3] = '{1'b0, 1'b0, 1'b1};
    bit          m_fault;
    logic [19:0] m_faddr;

    always #5 clock = ~clock;

    bus_fabric u_dut (
        .clock(clock), .reset(reset), .req(req), .we(we), .address(address),
        .out(wdata), .in(rdata), .ready(ready), .mem_a(mem_a), .mem_d(mem_d),
        .sel(sel), .wr(wr), .q(q), .fault_clr(fault_clr), .fault(fault),
        .fault_addr(fault_addr)
    );

    bus_fabric #(.BASE({20'hFF000, 20'h00000, 20'h00000})) u_ovl (
        .clock(clock), .reset(reset), .req(req_ovl), .we(we), .address(address),
        .out(wdata), .in(rdata_o), .ready(ready_o), .mem_a(mem_a_o), .mem_d(mem_d_o),
        .sel(sel_o), .wr(wr_o), .q(q), .fault_clr(fault_clr), .fault(fault_o),
        .fault_addr(fault_addr_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int ref_region(input logic [19:0] a);
        for (int i = 0; i < 3; i++) begin
            if ((a & m_mask[i]) == m_base[i]) return i;
        end
        return -1;
    endfunction

    // One CPU access; clr pulses fault_clr on the cycle the access completes.
    task automatic access(input logic [19:0] a, input logic w, input logic [7:0] d,
                          input logic [23:0] qv, input bit hold, input bit clr);
        int          r;
        int          lat;
        int          n;
        int          sel_n;
        int          sel_cnt;
        logic [2:0]  sel_or;
        logic [2:0]  wr_or;
        logic [2:0]  exp_oh;
        logic [2:0]  exp_wr;
        logic [7:0]  exp_in;
        logic [7:0]  qb [3];
        bit          got;
        bit          fevt;

        r       = ref_region(a);
        lat     = (r < 0) ? 2 : 3 + m_wait[(r < 0) ? 0 : r];
        qb[0]   = qv[7:0];
        qb[1]   = qv[15:8];
        qb[2]   = qv[23:16];
        exp_oh  = (r < 0) ? 3'b000 : 3'(1 << r);
        exp_in  = (r < 0) ? 8'hFF : qb[r];
        exp_wr  = 3'b000;
        fevt    = (r < 0);
        if (r >= 0) begin
            if (w && !m_ro[r]) exp_wr = exp_oh;
            if (w && m_ro[r])  fevt = 1'b1;
        end
        if (fevt) begin
            if (!m_fault || clr) m_faddr = a;
            m_fault = 1'b1;
        end else if (clr) begin
            m_fault = 1'b0;
        end

        q = qv; req = 1'b1; we = w; address = a; wdata = d;
        n = 0; got = 1'b0; sel_n = 0; sel_cnt = 0; sel_or = '0; wr_or = '0;
        while (!got && n < 24) begin
            fault_clr = clr && (n == lat - 1);
            @(posedge clock); #1;
            n++;
            if (sel != 3'b000) begin
                sel_cnt++;
                sel_n = n;
                sel_or |= sel;
                chk("mem_a", 32'(mem_a), 32'(a));
                chk("mem_d", 32'(mem_d), 32'(d));
            end
            wr_or |= wr;
            if (ready) got = 1'b1;
        end
        fault_clr = 1'b0;
        chk("ready_seen", 32'(got), 32'd1);
        chk("latency", n, lat);
        chk("rdata", 32'(rdata), 32'(exp_in));
        chk("sel", 32'(sel_or), 32'(exp_oh));
        chk("wr", 32'(wr_or), 32'(exp_wr));
        if (r >= 0) begin
            chk("sel_pulses", sel_cnt, 1);
            chk("sel_cycle", sel_n, 1 + m_wait[r]);
        end
        chk("fault", 32'(fault), 32'(m_fault));
        chk("fault_addr", 32'(fault_addr), 32'(m_faddr));

        req = hold;
        @(posedge clock); #1;
        req = 1'b0;
        chk("ready_pulse", 32'(ready), 32'd0);
        chk("no_reaccept", 32'(sel), 32'd0);
        chk("rdata_hold", 32'(rdata), 32'(exp_in));
    endtask

    task automatic clear_fault();
        fault_clr = 1'b1;
        @(posedge clock); #1;
        fault_clr = 1'b0;
        m_fault = 1'b0;
        chk("fault_clr", 32'(fault), 32'd0);
        chk("fault_addr_keep", 32'(fault_addr), 32'(m_faddr));
    endtask

    // Second instance: region 1 also claims 00000, region 0 must still win.
    task automatic overlap_read();
        int         n;
        bit         got;
        logic [2:0] sel_or;
        q = {8'h33, 8'hC3, 8'h96};
        req_ovl = 1'b1; we = 1'b0; address = 20'h00100; wdata = 8'h2C;
        n = 0; got = 1'b0; sel_or = '0;
        while (!got && n < 24) begin
            @(posedge clock); #1;
            n++;
            sel_or |= sel_o;
            chk("ovl_wr", 32'(wr_o), 32'd0);
            if (ready_o) got = 1'b1;
        end
        req_ovl = 1'b0;
        chk("ovl_latency", n, 3);
        chk("ovl_sel", 32'(sel_or), 32'b001);
        chk("ovl_rdata", 32'(rdata_o), 32'h96);
        chk("ovl_mem_a", 32'(mem_a_o), 32'h00100);
        chk("ovl_mem_d", 32'(mem_d_o), 32'h2C);
        chk("ovl_fault", 32'(fault_o), 32'd0);
        chk("ovl_fault_addr", 32'(fault_addr_o), 32'd0);
        @(posedge clock); #1;
    endtask

    task automatic reset_in_wait();
        int hits;
        req = 1'b1; we = 1'b1; address = 20'hB8010; wdata = 8'h99;
        @(posedge clock); #1;
        chk("wait_no_sel", 32'(sel), 32'd0);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0; req = 1'b0; we = 1'b0;
        m_fault = 1'b0; m_faddr = '0;
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_wr", 32'(wr), 32'd0);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'hFF);
        chk("rst_fault", 32'(fault), 32'd0);
        hits = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clock); #1;
            if (ready || sel != 3'b000 || wr != 3'b000) hits++;
        end
        chk("abort_quiet", hits, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation timeout");
    end

    initial begin
        logic [19:0] a;
        reset = 1'b1; req = 1'b0; req_ovl = 1'b0; we = 1'b0; address = '0;
        wdata = '0; q = '0; fault_clr = 1'b0;
        m_fault = 1'b0; m_faddr = '0;
        repeat (2) @(posedge clock);
        #1;
        chk("reset_sel", 32'(sel), 32'd0);
        chk("reset_wr", 32'(wr), 32'd0);
        chk("reset_ready", 32'(ready), 32'd0);
        chk("reset_fault", 32'(fault), 32'd0);
        chk("reset_rdata", 32'(rdata), 32'hFF);
        chk("reset_mem_a", 32'(mem_a), 32'd0);
        chk("reset_mem_d", 32'(mem_d), 32'd0);
        chk("reset_fault_addr", 32'(fault_addr), 32'd0);
        reset = 1'b0;
        @(posedge clock); #1;

        access(20'h00010, 1'b0, 8'h00, {8'h11, 8'h22, 8'h5A}, 1'b1, 1'b0);
        access(20'hB8002, 1'b1, 8'h41, {8'h11, 8'h22, 8'h5A}, 1'b0, 1'b0);
        access(20'hFF123, 1'b1, 8'h77, {8'hE7, 8'h22, 8'h5A}, 1'b0, 1'b0);
        access(20'h30000, 1'b0, 8'h00, {8'hE7, 8'h22, 8'h5A}, 1'b1, 1'b0);
        clear_fault();
        access(20'h30000, 1'b1, 8'h12, {8'hE7, 8'h22, 8'h5A}, 1'b0, 1'b0);
        access(20'hFF800, 1'b1, 8'h34, {8'hE7, 8'h22, 8'h5A}, 1'b0, 1'b1);
        clear_fault();

        overlap_read();
        reset_in_wait();

        for (int k = 0; k < 80; k++) begin
            case ($urandom % 4)
                0:       a = 20'($urandom) & 20'h1FFFF;
                1:       a = 20'hB8000 | 20'($urandom % 4096);
                2:       a = 20'hFF000 | 20'($urandom % 4096);
                default: a = 20'($urandom);
            endcase
            access(a, 1'($urandom % 2), 8'($urandom), 24'($urandom),
                   1'($urandom % 2), ($urandom % 4) == 0);
            if ($urandom % 8 == 0) clear_fault();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
